// File: rtl/serial_loop_fifo_if.sv
// Receiver/transmitter/flow-control bundle for serial_loop_fifo.
// The master side drives received characters and transmitter status; the slave side is the buffer.
interface serial_loop_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] rx_data;
  logic             rx_finish;
  logic [WIDTH-1:0] tx_data;
  logic             tx_send;
  logic             tx_ready;
  logic             cts;
  logic             rts;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             ovf_clr;

  modport master (
    output rx_data, rx_finish, tx_ready, rts, ovf_clr,
    input  tx_data, tx_send, cts, level, overflow
  );

  modport slave (
    input  rx_data, rx_finish, tx_ready, rts, ovf_clr,
    output tx_data, tx_send, cts, level, overflow
  );
endinterface

// File: rtl/serial_loop_fifo.sv
// Count-based receive-to-transmit FIFO with selectable overflow policy, sticky overflow flag,
// cts/rts flow control and a three-state transmit handshake.
module serial_loop_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL     = 12,
  parameter bit          OVERWRITE = 1'b0
) (
  input logic              clk,
  input logic              rst,
  serial_loop_fifo_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] tx_data_q;
  logic             tx_send_q, tx_send_d;
  logic             ovf_q, cts_q;
  logic             full, empty;
  logic             pop, push_acc, push_ovw, ovf_set;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // rts only gates the start of a character; an accepted character always completes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!empty && bus.tx_ready && !bus.rts) state_d = StBusy;
      StBusy:  if (!bus.tx_ready) state_d = StDone;
      StDone:  if (bus.tx_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pop       = (state_q == StIdle) && (state_d == StBusy);
    tx_send_d = (state_d == StBusy);
  end

  // A pop in the same cycle frees a slot, so a push into a full FIFO is then accepted.
  always_comb begin
    push_acc = bus.rx_finish && (!full || pop);
    ovf_set  = bus.rx_finish && full && !pop;
    push_ovw = ovf_set && OVERWRITE;
    level_d  = level_q;
    if (push_acc && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push_acc) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (push_acc || push_ovw)) begin
      mem[wr_ptr_q] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
      ovf_q     <= 1'b0;
      cts_q     <= 1'b0;
    end else begin
      if (push_acc || push_ovw) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      // Overwrite never coincides with a pop, so rd_ptr moves by at most one.
      if (pop || push_ovw) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (pop) begin
        tx_data_q <= mem[rd_ptr_q];
      end
      level_q   <= level_d;
      tx_send_q <= tx_send_d;
      cts_q     <= (32'(level_d) >= AFULL);
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_send  = tx_send_q;
  assign bus.cts      = cts_q;
  assign bus.level    = level_q;
  assign bus.overflow = ovf_q;
endmodule
